ring_buff_ctrl_mc: RTL and testbench
====================================

// Module: ring_buff_ctrl_mc
// PURPOSE
//  Multi-channel ring-buffer controller: NUM_CH independent read/write pointer pairs over one
//  shared storage array partitioned into NUM_CH regions of NUM_ENTRY entries each.
//  Generates physical addresses, occupancy counts, full/empty/almost-full flags,
//  per-channel flush, and sticky overflow/underflow errors. Sits beside a single-port-per-direction
//  RAM in IComp buffering paths that previously instantiated one controller per stream.
// PARAMETERS
//  NUM_ENTRY   16  entries per channel; power of two, >= 2
//  NUM_CH      4   number of channels; >= 1
//  AF_MARGIN   2   almost-full asserted when count >= NUM_ENTRY-AF_MARGIN; 0 < AF_MARGIN < NUM_ENTRY
// PORTS  (WB=$clog2(NUM_ENTRY), CB=max(1,$clog2(NUM_CH)))
//  clock     in   1              clock, all state on rising edge
//  reset     in   1              asynchronous, active-low reset
//  I_We      in   1              write request
//  I_WCh     in   CB             write channel select
//  I_Re      in   1              read request
//  I_RCh     in   CB             read channel select
//  I_Flush   in   NUM_CH         per-channel flush (empty the channel)
//  I_ClrErr  in   1              clear all sticky error bits
//  O_WAddr   out  CB+WB          {I_WCh, wptr[WB-1:0]} of selected channel, combinational
//  O_RAddr   out  CB+WB          {I_RCh, rptr[WB-1:0]} of selected channel, combinational
//  O_WAck    out  1              write accepted this cycle (combinational)
//  O_RAck    out  1              read accepted this cycle (combinational)
//  O_Full    out  NUM_CH         count == NUM_ENTRY
//  O_AFull   out  NUM_CH         count >= NUM_ENTRY-AF_MARGIN
//  O_Empty   out  NUM_CH         count == 0
//  O_Num     out  NUM_CH*(WB+1)  per-channel occupancy, channel c at [c*(WB+1)+:WB+1]
//  O_Ovf     out  NUM_CH         sticky: write attempted while full
//  O_Udf     out  NUM_CH         sticky: read attempted while empty
// BEHAVIOUR
//  - Pointers are WB+1 bits (wrap bit); count = wptr - rptr modulo 2^(WB+1); count in 0..NUM_ENTRY.
//  - Reset (reset==0, async assert, sync-released by clock domain owner): all pointers 0, O_Ovf/O_Udf 0;
//    hence O_Empty all 1, O_Full/O_AFull 0, O_Num 0, acks 0 once inputs idle.
//  - Write accepted: O_WAck = I_We & ~Full[I_WCh] & ~I_Flush[I_WCh]; wptr[I_WCh] += 1 at next edge.
//  - Read accepted: O_RAck = I_Re & ~Empty[I_RCh] & ~I_Flush[I_RCh]; rptr[I_RCh] += 1 at next edge.
//  - Flags/O_Num derive from registered pointers only: an accepted op in cycle N is visible in N+1.
//  - Write on full channel: rejected, O_Ovf[ch] set next edge. Read on empty: rejected, O_Udf[ch] set.
//    Same-cycle read of a full channel does NOT permit a write (no fall-through); same-cycle write
//    to an empty channel does NOT permit a read.
//  - Same-channel accepted read+write: both pointers advance, count unchanged.
//  - Different-channel read+write: independent.
//  - Wrap: pointer NUM_ENTRY*2-1 -> 0; low WB bits wrap at NUM_ENTRY; count remains correct.
//  - Flush[ch]: both pointers of ch <- 0 at next edge; overrides any read/write to ch that cycle
//    (acks forced 0); does not touch error bits or other channels.
//  - I_ClrErr: all O_Ovf/O_Udf <- 0 at next edge; a new error in the same cycle wins (bit set).
//  - I_WCh/I_RCh >= NUM_CH: request rejected, no state change, no error flagged.
// STRUCTURE
//  - Package rb_pkg: localparam helpers (clog2-min-1 function for CB), typedef for pointer width
//    not expressible per-instance -> keep pointer typedefs local; package holds err_t enum
//    {ERR_NONE, ERR_OVF, ERR_UDF} used by monitors.
//  - Sub-module rb_chan_ptr (one per channel, generate loop): holds wptr/rptr, inc/flush inputs,
//    emits count/full/afull/empty. Top does channel decode, ack logic, address mux, error regs.
// TESTING  (NUM_ENTRY=16, NUM_CH=4, AF_MARGIN=2)
//  1 Reset mid-traffic: fill ch1 to 5, drop reset -> same cycle O_Num all 0, O_Empty=4'b1111, O_Ovf=0.
//  2 Fill ch2 with 16 writes -> O_AFull[2] after 14th, O_Full[2] after 16th; 17th write O_WAck=0, O_Ovf[2]=1.
//  3 Read empty ch0 -> O_RAck=0, O_Udf[0]=1; I_ClrErr -> 0 next cycle; clr+new underflow same cycle -> stays 1.
//  4 Wrap: 40 write/read pairs on ch3 -> O_RAddr sequence {3,0..15} repeats, O_Num[3] never exceeds 1.
//  5 Simultaneous: ch1 holds 8, write+read ch1 -> O_Num 8; write ch0+read ch1 -> ch0 +1, ch1 -1.
//  6 Flush ch2 (holding 10) with concurrent write to ch2 -> O_WAck=0, O_Num[2]=0, ch0/ch1/ch3 unchanged.

Source files
------------

// File: rtl/rb_pkg.sv
// Shared definitions for the multi-channel ring-buffer controller: channel-select width
// helper and the error classification used by monitors.
package rb_pkg;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_OVF  = 2'd1,
    ERR_UDF  = 2'd2
  } err_t;

  // A single channel still needs a one-bit select so the address stays well formed.
  function automatic int cb_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rb_chan_ptr.sv
// One channel's read/write pointer pair with wrap bit; derives occupancy and status flags
// purely from the registered pointers.
module rb_chan_ptr #(
  parameter  int NUM_ENTRY = 16,
  parameter  int AF_MARGIN = 2,
  localparam int WB        = $clog2(NUM_ENTRY)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          wr_inc,
  input  logic          rd_inc,
  input  logic          flush,
  output logic [WB-1:0] wptr_lo,
  output logic [WB-1:0] rptr_lo,
  output logic [WB:0]   count,
  output logic          full,
  output logic          afull,
  output logic          empty
);

  localparam logic [WB:0] PTR_ZERO = {(WB+1){1'b0}};
  localparam logic [WB:0] PTR_ONE  = {{WB{1'b0}}, 1'b1};
  localparam logic [WB:0] FULL_CNT = NUM_ENTRY[WB:0];
  localparam logic [WB:0] AF_CNT   = (NUM_ENTRY - AF_MARGIN);

  logic [WB:0] wptr_q, wptr_d;
  logic [WB:0] rptr_q, rptr_d;

  // Next-pointer selection: flush wins over any increment on this channel.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush) begin
      wptr_d = PTR_ZERO;
      rptr_d = PTR_ZERO;
    end else begin
      wptr_d = wr_inc ? (wptr_q + PTR_ONE) : wptr_q;
      rptr_d = rd_inc ? (rptr_q + PTR_ONE) : rptr_q;
    end
  end

  // Pointer registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr_q <= PTR_ZERO;
      rptr_q <= PTR_ZERO;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Modular difference of the wrap-bit pointers yields 0..NUM_ENTRY.
  assign count   = wptr_q - rptr_q;
  assign full    = (count == FULL_CNT);
  assign afull   = (count >= AF_CNT);
  assign empty   = (count == PTR_ZERO);
  assign wptr_lo = wptr_q[WB-1:0];
  assign rptr_lo = rptr_q[WB-1:0];

endmodule

// File: rtl/ring_buff_ctrl_mc.sv
// Multi-channel ring-buffer controller: per-channel pointer pairs over one partitioned RAM,
// with request decode, accept logic, address muxing and sticky overflow/underflow bits.
module ring_buff_ctrl_mc
  import rb_pkg::*;
#(
  parameter  int NUM_ENTRY = 16,
  parameter  int NUM_CH    = 4,
  parameter  int AF_MARGIN = 2,
  localparam int WB        = $clog2(NUM_ENTRY),
  localparam int CB        = cb_width(NUM_CH)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     I_We,
  input  logic [CB-1:0]            I_WCh,
  input  logic                     I_Re,
  input  logic [CB-1:0]            I_RCh,
  input  logic [NUM_CH-1:0]        I_Flush,
  input  logic                     I_ClrErr,
  output logic [CB+WB-1:0]         O_WAddr,
  output logic [CB+WB-1:0]         O_RAddr,
  output logic                     O_WAck,
  output logic                     O_RAck,
  output logic [NUM_CH-1:0]        O_Full,
  output logic [NUM_CH-1:0]        O_AFull,
  output logic [NUM_CH-1:0]        O_Empty,
  output logic [NUM_CH*(WB+1)-1:0] O_Num,
  output logic [NUM_CH-1:0]        O_Ovf,
  output logic [NUM_CH-1:0]        O_Udf
);

  localparam logic [NUM_CH-1:0] CH_ZERO = {NUM_CH{1'b0}};

  logic [NUM_CH-1:0] wr_sel_s, rd_sel_s, wr_inc_s, rd_inc_s;
  logic [NUM_CH-1:0] full_s, empty_s;
  logic [WB-1:0]     wlo_s [NUM_CH];
  logic [WB-1:0]     rlo_s [NUM_CH];
  logic [NUM_CH-1:0] ovf_q, ovf_d, udf_q, udf_d;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    rb_chan_ptr #(.NUM_ENTRY(NUM_ENTRY), .AF_MARGIN(AF_MARGIN)) u_ptr (
      .clock   (clock),
      .reset   (reset),
      .wr_inc  (wr_inc_s[c]),
      .rd_inc  (rd_inc_s[c]),
      .flush   (I_Flush[c]),
      .wptr_lo (wlo_s[c]),
      .rptr_lo (rlo_s[c]),
      .count   (O_Num[c*(WB+1) +: WB+1]),
      .full    (full_s[c]),
      .afull   (O_AFull[c]),
      .empty   (empty_s[c])
    );
  end

  // Channel decode, accept qualification and address mux; unmatched selects do nothing.
  always_comb begin
    wr_sel_s = CH_ZERO;
    rd_sel_s = CH_ZERO;
    wr_inc_s = CH_ZERO;
    rd_inc_s = CH_ZERO;
    O_WAddr  = {I_WCh, {WB{1'b0}}};
    O_RAddr  = {I_RCh, {WB{1'b0}}};
    for (int c = 0; c < NUM_CH; c++) begin
      wr_sel_s[c] = I_We & (I_WCh == CB'(c));
      rd_sel_s[c] = I_Re & (I_RCh == CB'(c));
      wr_inc_s[c] = wr_sel_s[c] & ~full_s[c] & ~I_Flush[c];
      rd_inc_s[c] = rd_sel_s[c] & ~empty_s[c] & ~I_Flush[c];
      O_WAddr     = (I_WCh == CB'(c)) ? {I_WCh, wlo_s[c]} : O_WAddr;
      O_RAddr     = (I_RCh == CB'(c)) ? {I_RCh, rlo_s[c]} : O_RAddr;
    end
    O_WAck = |wr_inc_s;
    O_RAck = |rd_inc_s;
  end

  // Sticky errors: clear first, then a same-cycle new error re-sets the bit.
  always_comb begin
    ovf_d = (I_ClrErr ? CH_ZERO : ovf_q) | (wr_sel_s & full_s  & ~I_Flush);
    udf_d = (I_ClrErr ? CH_ZERO : udf_q) | (rd_sel_s & empty_s & ~I_Flush);
  end

  // Error registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ovf_q <= CH_ZERO;
      udf_q <= CH_ZERO;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign O_Full  = full_s;
  assign O_Empty = empty_s;
  assign O_Ovf   = ovf_q;
  assign O_Udf   = udf_q;

endmodule

// File: tb/tb_ring_buff_ctrl_mc.sv
// Self-checking bench for ring_buff_ctrl_mc: directed scenarios plus randomized traffic,
// all checked against a fill-level/index model of each channel.
module tb_ring_buff_ctrl_mc;

  localparam int NE = 16;
  localparam int NC = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        I_We = 1'b0, I_Re = 1'b0, I_ClrErr = 1'b0;
  logic [1:0]  I_WCh = 2'd0, I_RCh = 2'd0;
  logic [3:0]  I_Flush = 4'd0;
  logic [5:0]  O_WAddr, O_RAddr;
  logic        O_WAck, O_RAck;
  logic [3:0]  O_Full, O_AFull, O_Empty, O_Ovf, O_Udf;
  logic [19:0] O_Num;

  int n_checks = 0;
  int n_errors = 0;

  // Model: occupancy, next write/read slot, sticky errors per channel.
  int m_cnt [NC];
  int m_wi  [NC];
  int m_ri  [NC];
  bit m_ovf [NC];
  bit m_udf [NC];

  bit         exp_wack, exp_rack, obs_wack, obs_rack;
  logic [5:0] exp_waddr, exp_raddr, obs_waddr, obs_raddr;

  ring_buff_ctrl_mc #(.NUM_ENTRY(16), .NUM_CH(4), .AF_MARGIN(2)) dut (
    .clock(clock), .reset(reset),
    .I_We(I_We), .I_WCh(I_WCh), .I_Re(I_Re), .I_RCh(I_RCh),
    .I_Flush(I_Flush), .I_ClrErr(I_ClrErr),
    .O_WAddr(O_WAddr), .O_RAddr(O_RAddr), .O_WAck(O_WAck), .O_RAck(O_RAck),
    .O_Full(O_Full), .O_AFull(O_AFull), .O_Empty(O_Empty), .O_Num(O_Num),
    .O_Ovf(O_Ovf), .O_Udf(O_Udf)
  );

  always #5 clock = ~clock;

  function automatic int num_of(input int c);
    logic [4:0] v;
    v = O_Num[c*5 +: 5];
    return int'(v);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      m_cnt[c] = 0; m_wi[c] = 0; m_ri[c] = 0; m_ovf[c] = 0; m_udf[c] = 0;
    end
  endtask

  // Drives one cycle (starting just after a rising edge), samples the combinational
  // outputs mid-cycle, and advances the model across the edge. Compares nothing.
  task automatic cycle(input bit we, input int wch, input bit re, input int rch,
                       input logic [3:0] fl, input bit clr);
    bit wfull, rempty;
    I_We = we; I_WCh = wch[1:0]; I_Re = re; I_RCh = rch[1:0];
    I_Flush = fl; I_ClrErr = clr;
    wfull  = (m_cnt[wch] == NE);
    rempty = (m_cnt[rch] == 0);
    exp_wack  = we && !wfull  && !fl[wch];
    exp_rack  = re && !rempty && !fl[rch];
    exp_waddr = {wch[1:0], 4'(m_wi[wch] % NE)};
    exp_raddr = {rch[1:0], 4'(m_ri[rch] % NE)};
    #1;
    obs_wack = O_WAck; obs_rack = O_RAck; obs_waddr = O_WAddr; obs_raddr = O_RAddr;
    @(posedge clock);
    #1;
    if (clr) for (int c = 0; c < NC; c++) begin m_ovf[c] = 0; m_udf[c] = 0; end
    if (we && wfull  && !fl[wch]) m_ovf[wch] = 1;
    if (re && rempty && !fl[rch]) m_udf[rch] = 1;
    if (exp_wack) begin m_cnt[wch]++; m_wi[wch] = (m_wi[wch] + 1) % NE; end
    if (exp_rack) begin m_cnt[rch]--; m_ri[rch] = (m_ri[rch] + 1) % NE; end
    for (int c = 0; c < NC; c++)
      if (fl[c]) begin m_cnt[c] = 0; m_wi[c] = 0; m_ri[c] = 0; end
    I_We = 1'b0; I_Re = 1'b0; I_Flush = 4'd0; I_ClrErr = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if (O_Empty !== 4'b1111 || O_Num !== 20'd0 || O_Full !== 4'd0 || O_AFull !== 4'd0) begin
      n_errors++;
      $display("FAIL reset_flags: empty=%b num=%h full=%b afull=%b, need 1111/0/0/0",
               O_Empty, O_Num, O_Full, O_AFull);
    end
    n_checks++;
    if (O_Ovf !== 4'd0 || O_Udf !== 4'd0 || O_WAck !== 1'b0 || O_RAck !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_err_ack: ovf=%b udf=%b wack=%b rack=%b, need 0", O_Ovf, O_Udf, O_WAck, O_RAck);
    end
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
    for (int i = 0; i < 5; i++) cycle(1, 1, 0, 0, 4'd0, 0);
    cycle(0, 0, 1, 0, 4'd0, 0);
    n_checks++;
    if (num_of(1) != 5 || O_Udf !== 4'b0001) begin
      n_errors++;
      $display("FAIL prefill_ch1: num1=%0d udf=%b, need 5/0001", num_of(1), O_Udf);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (O_Num !== 20'd0 || O_Empty !== 4'b1111 || O_Ovf !== 4'd0 || O_Udf !== 4'd0) begin
      n_errors++;
      $display("FAIL reset_midtraffic: num=%h empty=%b ovf=%b udf=%b, need 0/1111/0/0",
               O_Num, O_Empty, O_Ovf, O_Udf);
    end
    model_reset();
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_fill();
    for (int k = 1; k <= 16; k++) begin
      cycle(1, 2, 0, 0, 4'd0, 0);
      n_checks++;
      if (obs_wack !== 1'b1 || num_of(2) != k || O_AFull[2] !== (k >= 14) || O_Full[2] !== (k == 16)) begin
        n_errors++;
        $display("FAIL fill_ch2 k=%0d: wack=%b num=%0d afull=%b full=%b", k, obs_wack, num_of(2), O_AFull[2], O_Full[2]);
      end
    end
    cycle(1, 2, 0, 0, 4'd0, 0);
    n_checks++;
    if (obs_wack !== 1'b0 || O_Ovf !== 4'b0100 || num_of(2) != 16) begin
      n_errors++;
      $display("FAIL overflow_ch2: wack=%b ovf=%b num=%0d, need 0/0100/16", obs_wack, O_Ovf, num_of(2));
    end
    cycle(0, 0, 0, 0, 4'd0, 1);
    n_checks++;
    if (O_Ovf !== 4'd0) begin
      n_errors++;
      $display("FAIL clr_ovf: ovf=%b, need 0000", O_Ovf);
    end
  endtask

  task automatic test_underflow();
    cycle(0, 0, 1, 0, 4'd0, 0);
    n_checks++;
    if (obs_rack !== 1'b0 || O_Udf !== 4'b0001) begin
      n_errors++;
      $display("FAIL underflow_ch0: rack=%b udf=%b, need 0/0001", obs_rack, O_Udf);
    end
    cycle(0, 0, 0, 0, 4'd0, 1);
    n_checks++;
    if (O_Udf !== 4'd0) begin
      n_errors++;
      $display("FAIL clr_udf: udf=%b, need 0000", O_Udf);
    end
    cycle(0, 0, 1, 0, 4'd0, 1);
    n_checks++;
    if (O_Udf !== 4'b0001) begin
      n_errors++;
      $display("FAIL clr_vs_new_udf: udf=%b, need 0001", O_Udf);
    end
    cycle(0, 0, 0, 0, 4'd0, 1);
  endtask

  task automatic test_wrap();
    int max_num = 0;
    int bad = 0;
    for (int k = 0; k < 40; k++) begin
      cycle(1, 3, 0, 0, 4'd0, 0);
      if (num_of(3) > max_num) max_num = num_of(3);
      cycle(0, 0, 1, 3, 4'd0, 0);
      if (obs_raddr !== {2'd3, 4'(k % 16)} || obs_rack !== 1'b1) bad++;
      if (num_of(3) > max_num) max_num = num_of(3);
    end
    n_checks++;
    if (bad != 0 || max_num > 1 || num_of(3) != 0 || O_Udf !== 4'd0) begin
      n_errors++;
      $display("FAIL wrap_ch3: addr_errs=%0d max_num=%0d num=%0d udf=%b, need 0/<=1/0/0", bad, max_num, num_of(3), O_Udf);
    end
  endtask

  task automatic test_simultaneous();
    int n0;
    for (int i = 0; i < 8; i++) cycle(1, 1, 0, 0, 4'd0, 0);
    cycle(1, 1, 1, 1, 4'd0, 0);
    n_checks++;
    if (obs_wack !== 1'b1 || obs_rack !== 1'b1 || num_of(1) != 8) begin
      n_errors++;
      $display("FAIL same_ch_rw: wack=%b rack=%b num1=%0d, need 1/1/8", obs_wack, obs_rack, num_of(1));
    end
    n0 = num_of(0);
    cycle(1, 0, 1, 1, 4'd0, 0);
    n_checks++;
    if (num_of(0) != n0 + 1 || num_of(1) != 7) begin
      n_errors++;
      $display("FAIL diff_ch_rw: num0=%0d num1=%0d, need %0d/7", num_of(0), num_of(1), n0 + 1);
    end
  endtask

  task automatic test_flush();
    logic [4:0] keep0, keep1, keep3;
    for (int i = 0; i < 6; i++) cycle(0, 0, 1, 2, 4'd0, 0);
    keep0 = O_Num[4:0]; keep1 = O_Num[9:5]; keep3 = O_Num[19:15];
    n_checks++;
    if (num_of(2) != 10) begin
      n_errors++;
      $display("FAIL preflush_ch2: num2=%0d, need 10", num_of(2));
    end
    cycle(1, 2, 0, 0, 4'b0100, 0);
    n_checks++;
    if (obs_wack !== 1'b0 || num_of(2) != 0 || O_Empty[2] !== 1'b1 ||
        O_Num[4:0] !== keep0 || O_Num[9:5] !== keep1 || O_Num[19:15] !== keep3) begin
      n_errors++;
      $display("FAIL flush_ch2: wack=%b num=%h empty2=%b, need 0 and ch2=0 others %0d/%0d/%0d",
               obs_wack, O_Num, O_Empty[2], keep0, keep1, keep3);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      logic [3:0] fl;
      fl = ($urandom_range(0, 15) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'd0;
      cycle($urandom_range(0, 2) != 0, $urandom_range(0, 3), $urandom_range(0, 2) != 0,
            $urandom_range(0, 3), fl, $urandom_range(0, 15) == 0);
      n_checks++;
      if (obs_wack !== exp_wack || obs_rack !== exp_rack || obs_waddr !== exp_waddr || obs_raddr !== exp_raddr) begin
        n_errors++;
        $display("FAIL rand_ack_addr n=%0d: wack=%b/%b rack=%b/%b waddr=%h/%h raddr=%h/%h (got/need)",
                 n, obs_wack, exp_wack, obs_rack, exp_rack, obs_waddr, exp_waddr, obs_raddr, exp_raddr);
      end
      for (int c = 0; c < NC; c++) begin
        n_checks++;
        if (num_of(c) != m_cnt[c] || O_Full[c] !== (m_cnt[c] == NE) || O_AFull[c] !== (m_cnt[c] >= NE - 2) ||
            O_Empty[c] !== (m_cnt[c] == 0) || O_Ovf[c] !== m_ovf[c] || O_Udf[c] !== m_udf[c]) begin
          n_errors++;
          $display("FAIL rand_state n=%0d ch=%0d: num=%0d/%0d full=%b afull=%b empty=%b ovf=%b/%b udf=%b/%b",
                   n, c, num_of(c), m_cnt[c], O_Full[c], O_AFull[c], O_Empty[c], O_Ovf[c], m_ovf[c], O_Udf[c], m_udf[c]);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fill();
    test_underflow();
    test_wrap();
    test_simultaneous();
    test_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
